// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_sched_if
// Brief   : Request/ack and divider-output bundle for clk_div_sched.
// Revision: 1.0 - initial release
// ============================================================================
interface clk_div_sched_if #(
    parameter int N_REQ   = 2,
    parameter int RATIO_W = 4
);
    logic                       en;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*RATIO_W-1:0]   req_ratio;
    logic [N_REQ-1:0]           ack;
    logic [N_REQ-1:0]           err;
    logic                       busy;
    logic [RATIO_W-1:0]         cur_ratio;
    logic                       div_out;
    logic                       tick;

    modport master (
        output en, req, req_ratio,
        input  ack, err, busy, cur_ratio, div_out, tick
    );

    modport slave (
        input  en, req, req_ratio,
        output ack, err, busy, cur_ratio, div_out, tick
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_sched
// Brief   : Reprogrammable integer clock divider with round-robin ratio requests.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int N_REQ     = 2,
    parameter int RATIO_W   = 4,
    parameter int DEF_RATIO = 7
) (
    input  wire logic       clk_in,
    input  wire logic       rst,
    clk_div_sched_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic                 rej_q, rej_d;
    logic [RATIO_W-1:0]   pend_ratio_q, pend_ratio_d;
    logic [RATIO_W-1:0]   cur_ratio_q, cur_ratio_d;
    logic [RATIO_W-1:0]   p_q, p_d;
    logic                 div_out_q, div_out_d;
    logic                 tick_q, tick_d;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     grant_next_ptr;
    logic [RATIO_W-1:0]   grant_ratio;
    logic                 wrap;

    // First asserted requester at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_found && bus.req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
        grant_next_ptr = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        grant_ratio    = bus.req_ratio[int'(grant_idx)*RATIO_W +: RATIO_W];
    end

    assign wrap = (p_q == cur_ratio_q - RATIO_W'(1));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        rej_d        = rej_q;
        pend_ratio_d = pend_ratio_q;
        cur_ratio_d  = cur_ratio_q;
        p_d          = p_q;
        div_out_d    = div_out_q;
        tick_d       = 1'b0;

        if (bus.en) begin
            div_out_d = (p_q < (cur_ratio_q >> 1));
            tick_d    = wrap;
            p_d       = wrap ? '0 : p_q + RATIO_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (grant_found) begin
                    gnt_d = grant_idx;
                    ptr_d = grant_next_ptr;
                    if (grant_ratio >= RATIO_W'(2)) begin
                        pend_ratio_d = grant_ratio;
                        rej_d        = 1'b0;
                        state_d      = ST_PEND;
                    end else begin
                        rej_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_PEND: begin
                // A frozen divider has no boundary to wait for, so apply at once.
                if (!bus.en) begin
                    cur_ratio_d = pend_ratio_q;
                    p_d         = '0;
                    state_d     = ST_ACK;
                end else if (wrap) begin
                    cur_ratio_d = pend_ratio_q;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_RUN;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rej_q        <= 1'b0;
            pend_ratio_q <= RATIO_W'(DEF_RATIO);
            cur_ratio_q  <= RATIO_W'(DEF_RATIO);
            p_q          <= '0;
            div_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rej_q        <= rej_d;
            pend_ratio_q <= pend_ratio_d;
            cur_ratio_q  <= cur_ratio_d;
            p_q          <= p_d;
            div_out_q    <= div_out_d;
            tick_q       <= tick_d;
        end
    end

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_resp
            assign bus.ack[i] = (state_q == ST_ACK) && !rej_q && (gnt_q == IDX_W'(i));
            assign bus.err[i] = (state_q == ST_ACK) &&  rej_q && (gnt_q == IDX_W'(i));
        end
    endgenerate

    assign bus.busy      = (state_q == ST_PEND) || (state_q == ST_ACK);
    assign bus.cur_ratio = cur_ratio_q;
    assign bus.div_out   = div_out_q;
    assign bus.tick      = tick_q;
endmodule
`default_nettype wire
